// File: rtl/qr_stage_seq_pkg.sv
// Shared definitions for the QR stage sequencer: FSM encoding, stage codes,
// timeout default and small state-decoding helpers.
package qr_stage_seq_pkg;

  localparam int unsigned CNT_W = 24;
  localparam logic [CNT_W-1:0] TIMEOUT_CYCLES_DEFAULT = 24'd1000000;

  localparam logic [1:0] STAGE_NONE = 2'd0;
  localparam logic [1:0] STAGE_BIN  = 2'd1;
  localparam logic [1:0] STAGE_LOC  = 2'd2;
  localparam logic [1:0] STAGE_SMP  = 2'd3;

  typedef enum logic [3:0] {
    IDLE,
    BIN_RUN,
    BIN_REL,
    LOC_RUN,
    LOC_REL,
    SMP_RUN,
    SMP_REL,
    DONE,
    ERR
  } state_t;

  function automatic logic [1:0] stage_of(state_t s);
    case (s)
      BIN_RUN, BIN_REL: return STAGE_BIN;
      LOC_RUN, LOC_REL: return STAGE_LOC;
      SMP_RUN, SMP_REL: return STAGE_SMP;
      default:          return STAGE_NONE;
    endcase
  endfunction

  function automatic logic is_rel(state_t s);
    return (s inside {BIN_REL, LOC_REL, SMP_REL});
  endfunction

  // Successor on a completed handshake step; only meaningful for RUN/REL states.
  function automatic state_t next_phase(state_t s);
    case (s)
      BIN_RUN: return BIN_REL;
      BIN_REL: return LOC_RUN;
      LOC_RUN: return LOC_REL;
      LOC_REL: return SMP_RUN;
      SMP_RUN: return SMP_REL;
      SMP_REL: return DONE;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/qr_stage_seq_stage_hs.sv
// stage_hs: en/end handshake step detection and saturating phase timeout
// counter for whichever stage the sequencer currently has active.
module stage_hs
  import qr_stage_seq_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_rel,
  input  logic i_end,
  input  logic i_state_change,
  output logic o_adv,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LAST_CYCLE = TIMEOUT_CYCLES - CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_state_change) begin
      r_count <= '0;
    end else if (i_active && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // RUN waits for end to rise, REL waits for it to fall again.
  assign o_adv     = i_active & (i_rel ? ~i_end : i_end);
  assign o_timeout = i_active & (r_count == LAST_CYCLE);

endmodule

// File: rtl/qr_stage_seq.sv
// qr_stage_seq: runs the bin -> loc -> smp stage chain over level en/end
// handshakes, sharing one image-RAM read address and one timeout counter.
module qr_stage_seq
  import qr_stage_seq_pkg::*;
#(
  parameter int unsigned      ADDR_WIDTH_2   = 16,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [1:0]              err_stage,
  output logic                    bin_en,
  output logic                    loc_en,
  output logic                    smp_en,
  input  logic                    bin_end,
  input  logic                    loc_end,
  input  logic                    smp_end,
  input  logic [ADDR_WIDTH_2-1:0] bin_addr,
  input  logic [ADDR_WIDTH_2-1:0] loc_addr,
  input  logic [ADDR_WIDTH_2-1:0] smp_addr,
  output logic [ADDR_WIDTH_2-1:0] ram_addr
);

  state_t r_state;
  state_t w_next;

  logic [1:0]              w_stage;
  logic                    w_active;
  logic                    w_rel;
  logic                    w_end;
  logic                    w_adv;
  logic                    w_timeout;
  logic                    w_state_change;

  logic                    w_busy_nxt;
  logic                    w_done_nxt;
  logic                    w_err_nxt;
  logic [1:0]              w_err_stage_nxt;
  logic                    w_bin_en_nxt;
  logic                    w_loc_en_nxt;
  logic                    w_smp_en_nxt;
  logic [ADDR_WIDTH_2-1:0] w_addr_nxt;

  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [1:0]              r_err_stage;
  logic                    r_bin_en;
  logic                    r_loc_en;
  logic                    r_smp_en;
  logic [ADDR_WIDTH_2-1:0] r_ram_addr;

  assign w_stage        = stage_of(r_state);
  assign w_active       = (w_stage != STAGE_NONE);
  assign w_rel          = is_rel(r_state);
  assign w_state_change = (w_next != r_state);

  always_comb begin
    case (w_stage)
      STAGE_BIN: w_end = bin_end;
      STAGE_LOC: w_end = loc_end;
      STAGE_SMP: w_end = smp_end;
      default:   w_end = 1'b0;
    endcase
  end

  stage_hs #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_stage_hs (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_active      (w_active),
    .i_rel         (w_rel),
    .i_end         (w_end),
    .i_state_change(w_state_change),
    .o_adv         (w_adv),
    .o_timeout     (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Priority inside a running stage: abort, then handshake step, then timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start && !abort) w_next = BIN_RUN;
      end
      default: begin
        if (abort)          w_next = IDLE;
        else if (w_adv)     w_next = next_phase(r_state);
        else if (w_timeout) w_next = ERR;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they register alongside it.
  always_comb begin
    w_bin_en_nxt    = (w_next == BIN_RUN);
    w_loc_en_nxt    = (w_next == LOC_RUN);
    w_smp_en_nxt    = (w_next == SMP_RUN);
    w_busy_nxt      = (stage_of(w_next) != STAGE_NONE);
    w_done_nxt      = (w_next == DONE);
    w_err_nxt       = r_err;
    w_err_stage_nxt = r_err_stage;
    if (!w_active && (w_next == BIN_RUN)) begin
      w_err_nxt       = 1'b0;
      w_err_stage_nxt = STAGE_NONE;
    end else if (w_active && (w_next == ERR)) begin
      w_err_nxt       = 1'b1;
      w_err_stage_nxt = w_stage;
    end
    case (stage_of(w_next))
      STAGE_BIN: w_addr_nxt = bin_addr;
      STAGE_LOC: w_addr_nxt = loc_addr;
      STAGE_SMP: w_addr_nxt = smp_addr;
      default:   w_addr_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_stage <= STAGE_NONE;
      r_bin_en    <= 1'b0;
      r_loc_en    <= 1'b0;
      r_smp_en    <= 1'b0;
      r_ram_addr  <= '0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_err_stage <= w_err_stage_nxt;
      r_bin_en    <= w_bin_en_nxt;
      r_loc_en    <= w_loc_en_nxt;
      r_smp_en    <= w_smp_en_nxt;
      r_ram_addr  <= w_addr_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_stage = r_err_stage;
  assign bin_en    = r_bin_en;
  assign loc_en    = r_loc_en;
  assign smp_en    = r_smp_en;
  assign ram_addr  = r_ram_addr;

endmodule

// File: tb/tb_qr_stage_seq.sv
// Testbench for qr_stage_seq: reactive stage responders plus a behavioural
// model of the chain, compared against the DUT each cycle.
module tb_qr_stage_seq;

  localparam int AW  = 16;
  localparam int TMO = 50;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic          abort    = 1'b0;
  logic [AW-1:0] bin_addr = '0;
  logic [AW-1:0] loc_addr = '0;
  logic [AW-1:0] smp_addr = '0;
  logic          busy, done, err, bin_en, loc_en, smp_en;
  logic [1:0]    err_stage;
  logic [AW-1:0] ram_addr;

  logic [2:0] resp_on   = 3'b111;
  logic [2:0] resp_end  = 3'b000;
  logic [2:0] force_end = 3'b000;
  wire  [2:0] ends      = (resp_on & resp_end) | (~resp_on & force_end);
  wire  [2:0] ens       = {smp_en, loc_en, bin_en};
  wire  [23:0] dut_vec  = {busy, done, err, err_stage, bin_en, loc_en, smp_en, ram_addr};

  int unsigned hi_dly[3] = '{10, 10, 10};
  int unsigned lo_dly[3] = '{2, 2, 2};
  int unsigned hi_cnt[3] = '{0, 0, 0};
  int unsigned lo_cnt[3] = '{0, 0, 0};
  bit          rand_dly  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: active stage number (0 = none), release flag, idle/done/err mode.
  int            m_stage     = 0;
  int            m_mode      = 0;
  int            m_cyc       = 0;
  bit            m_rel       = 1'b0;
  bit            m_err       = 1'b0;
  logic [1:0]    m_err_stage = 2'd0;
  logic [AW-1:0] m_addr      = '0;

  always #5 clk = ~clk;

  qr_stage_seq #(
    .ADDR_WIDTH_2  (AW),
    .TIMEOUT_CYCLES(24'd50)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_stage(err_stage),
    .bin_en   (bin_en),
    .loc_en   (loc_en),
    .smp_en   (smp_en),
    .bin_end  (ends[0]),
    .loc_end  (ends[1]),
    .smp_end  (ends[2]),
    .bin_addr (bin_addr),
    .loc_addr (loc_addr),
    .smp_addr (smp_addr),
    .ram_addr (ram_addr)
  );

  always @(posedge clk) begin
    int nst;
    int nmode;
    bit nrel;
    bit chg;
    bit e;
    if (!rst_n) begin
      m_stage = 0; m_mode = 0; m_cyc = 0; m_rel = 1'b0;
      m_err = 1'b0; m_err_stage = 2'd0; m_addr = '0;
    end else begin
      nst = m_stage; nrel = m_rel; nmode = m_mode; chg = 1'b0;
      if (m_stage == 0) begin
        if (start && !abort) begin
          nst = 1; nrel = 1'b0; chg = 1'b1; m_err = 1'b0; m_err_stage = 2'd0;
        end
      end else if (abort) begin
        nst = 0; nmode = 0; chg = 1'b1;
      end else begin
        e = ends[m_stage-1];
        if (!m_rel && e) begin
          nrel = 1'b1; chg = 1'b1;
        end else if (m_rel && !e) begin
          chg = 1'b1;
          if (m_stage == 3) begin nst = 0; nmode = 1; end
          else begin nst = m_stage + 1; nrel = 1'b0; end
        end else if (m_cyc == TMO - 1) begin
          nst = 0; nmode = 2; chg = 1'b1; m_err = 1'b1; m_err_stage = 2'(m_stage);
        end
      end
      case (nst)
        1:       m_addr = bin_addr;
        2:       m_addr = loc_addr;
        3:       m_addr = smp_addr;
        default: m_addr = '0;
      endcase
      m_cyc   = chg ? 0 : m_cyc + 1;
      m_stage = nst; m_rel = nrel; m_mode = nmode;
    end
  end

  // Stage responders: raise end hi_dly cycles after en, drop it lo_dly after en falls.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (!rst_n) begin
        resp_end[s] = 1'b0; hi_cnt[s] = 0; lo_cnt[s] = 0;
      end else if (ens[s]) begin
        lo_cnt[s] = 0;
        if (!resp_end[s]) begin
          if (hi_cnt[s] >= hi_dly[s]) resp_end[s] = 1'b1;
          else hi_cnt[s]++;
        end
      end else begin
        hi_cnt[s] = 0;
        if (resp_end[s]) begin
          if (lo_cnt[s] >= lo_dly[s]) begin
            resp_end[s] = 1'b0; lo_cnt[s] = 0;
            if (rand_dly) begin
              hi_dly[s] = $urandom_range(0, 60);
              lo_dly[s] = $urandom_range(0, 4);
            end
          end else begin
            lo_cnt[s]++;
          end
        end
      end
    end
  end

  function automatic logic [23:0] exp_vec();
    return {m_stage != 0, (m_stage == 0) && (m_mode == 1), m_err, m_err_stage,
            (m_stage == 1) && !m_rel, (m_stage == 2) && !m_rel, (m_stage == 3) && !m_rel, m_addr};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    resp_on = 3'b111; force_end = 3'b000; rand_dly = 1'b0;
    for (int s = 0; s < 3; s++) begin hi_dly[s] = 10; lo_dly[s] = 2; end
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b0;
    tick(); tick();
    start = 1'b0;
    n_tests++;
    if (dut_vec !== 24'h0) begin
      n_fail++; $display("[TB] FAIL reset_values: got %h expected %h", dut_vec, 24'h0);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (dut_vec !== 24'h0) begin
      n_fail++; $display("[TB] FAIL reset_idle: got %h expected %h", dut_vec, 24'h0);
    end
  endtask

  task automatic test_nominal();
    int order = 0;
    logic [2:0] prev = 3'b000;
    do_reset();
    bin_addr = 16'($urandom); loc_addr = 16'($urandom); smp_addr = 16'($urandom);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL nominal_vec: got %h expected %h", dut_vec, exp_vec());
      end
      n_tests++;
      if (!$onehot0(ens)) begin
        n_fail++; $display("[TB] FAIL nominal_onehot: got en %b expected at most one high", ens);
      end
      if ((ens & ~prev) != 3'b000) order = order * 10 + (ens[0] ? 1 : (ens[1] ? 2 : 3));
      prev = ens;
      if (m_stage == 0) break;
      tick();
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL nominal_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    n_tests++;
    if (order != 123) begin
      n_fail++; $display("[TB] FAIL nominal_order: got %0d expected 123", order);
    end
  endtask

  task automatic test_timeout();
    int loc_cycles = 0;
    do_reset();
    hi_dly[1] = 1000;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (loc_en) loc_cycles++;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL timeout_vec: got %h expected %h", dut_vec, exp_vec());
      end
      if (m_stage == 0) break;
      tick();
    end
    n_tests++;
    if (err !== 1'b1 || err_stage !== 2'd2 || loc_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_err: got err=%b err_stage=%0d loc_en=%b busy=%b expected 1 2 0 0",
               err, err_stage, loc_en, busy);
    end
    n_tests++;
    if (loc_cycles != TMO) begin
      n_fail++; $display("[TB] FAIL timeout_len: got %0d loc_en cycles expected %0d", loc_cycles, TMO);
    end
  endtask

  task automatic test_abort();
    int c;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (c = 0; c < 300; c++) begin
      if (m_stage == 3 && !m_rel && m_cyc >= 3) break;
      tick();
    end
    n_tests++;
    if (c == 300 || smp_en !== 1'b1) begin
      n_fail++; $display("[TB] FAIL abort_reach: got smp_en=%b expected 1 (SMP_RUN)", smp_en);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    n_tests++;
    if (smp_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_idle: got smp_en=%b busy=%b done=%b err=%b expected all 0",
               smp_en, busy, done, err);
    end
    start = 1'b1; tick(); start = 1'b0;
    n_tests++;
    if (bin_en !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL abort_restart: got bin_en=%b busy=%b expected 1 1", bin_en, busy);
    end
  endtask

  task automatic test_addr();
    logic [AW-1:0] want [4];
    want[0] = 16'h0000; want[1] = 16'h0011; want[2] = 16'h0022; want[3] = 16'h0033;
    do_reset();
    bin_addr = want[1]; loc_addr = want[2]; smp_addr = want[3];
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (m_stage != 0 && !m_rel && m_cyc == 1) begin
        n_tests++;
        if (ram_addr !== want[m_stage]) begin
          n_fail++; $display("[TB] FAIL addr_stage%0d: got %h expected %h", m_stage, ram_addr, want[m_stage]);
        end
      end
      if (m_stage == 0) break;
      tick();
    end
    tick();
    n_tests++;
    if (ram_addr !== 16'h0000 || done !== 1'b1) begin
      n_fail++; $display("[TB] FAIL addr_done: got ram_addr=%h done=%b expected 0000 1", ram_addr, done);
    end
  endtask

  task automatic test_reset_midrun();
    int c;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (c = 0; c < 300; c++) begin
      if (m_stage == 2 && m_rel) break;
      tick();
    end
    n_tests++;
    if (c == 300 || busy !== 1'b1 || loc_en !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rstmid_reach: got busy=%b loc_en=%b expected 1 0 (LOC_REL)", busy, loc_en);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_tests++;
    if (dut_vec !== 24'h0) begin
      n_fail++; $display("[TB] FAIL rstmid_values: got %h expected %h", dut_vec, 24'h0);
    end
    start = 1'b1; tick(); start = 1'b0;
    n_tests++;
    if (bin_en !== 1'b1 || loc_en !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rstmid_restart: got bin_en=%b loc_en=%b busy=%b err=%b expected 1 0 1 0",
               bin_en, loc_en, busy, err);
    end
  endtask

  task automatic test_edges();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    n_tests++;
    if (bin_en !== 1'b1 || busy !== 1'b1 || dut_vec !== exp_vec()) begin
      n_fail++; $display("[TB] FAIL start_busy: got %h expected %h with bin_en=1", dut_vec, exp_vec());
    end
    do_reset();
    resp_on = 3'b110; force_end = 3'b001;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    n_tests++;
    if (bin_en !== 1'b1) begin
      n_fail++; $display("[TB] FAIL end_high_run: got bin_en=%b expected 1", bin_en);
    end
    tick();
    n_tests++;
    if (bin_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("[TB] FAIL end_high_rel: got bin_en=%b busy=%b expected 0 1", bin_en, busy);
    end
    do_reset();
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || bin_en !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_start: got busy=%b bin_en=%b done=%b expected 0 0 0", busy, bin_en, done);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || bin_en !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_start_hold: got busy=%b bin_en=%b expected 0 0", busy, bin_en);
    end
  endtask

  task automatic test_random();
    do_reset();
    rand_dly = 1'b1;
    for (int s = 0; s < 3; s++) begin
      hi_dly[s] = $urandom_range(0, 60);
      lo_dly[s] = $urandom_range(0, 4);
    end
    for (int c = 0; c < 3000; c++) begin
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 49) == 0);
      rst_n    = ($urandom_range(0, 399) != 0);
      bin_addr = 16'($urandom);
      loc_addr = 16'($urandom);
      smp_addr = 16'($urandom);
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL random_vec cycle %0d: got %h expected %h", c, dut_vec, exp_vec());
      end
      n_tests++;
      if (!$onehot0(ens)) begin
        n_fail++; $display("[TB] FAIL random_onehot cycle %0d: got en %b expected at most one high", c, ens);
      end
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1; rand_dly = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_abort();
    test_addr();
    test_reset_midrun();
    test_edges();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
